// File: rtl/soc_system_pio_multi.sv
// rtl/soc_system_pio_multi.sv - multi-channel output PIO with atomic set/clear/toggle and hardware blink
module soc_system_pio_multi #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH_AW+2:0]         address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [3:0]               byteenable,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_SET    = 3'd1;
  localparam logic [2:0] REG_CLEAR  = 3'd2;
  localparam logic [2:0] REG_TOGGLE = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;
  localparam logic [2:0] REG_DIV    = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [DATA_W-1:0] mask_q [NUM_CH];
  logic [DATA_W-1:0] mask_d [NUM_CH];
  logic [31:0]       blink_div_q, blink_div_d;
  logic [31:0]       counter_q, counter_d;
  logic              phase_q, phase_d;
  logic [31:0]       readdata_q, readdata_d;

  logic [CH_AW-1:0]  ch_idx;
  logic [2:0]        reg_sel;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       be_bits;
  logic [31:0]       wd_be;
  logic [DATA_W-1:0] be_w;
  logic [DATA_W-1:0] wd_w;
  logic              div_wr;

  assign ch_idx  = address[CH_AW+2:3];
  assign reg_sel = address[2:0];
  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign be_bits = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign wd_be   = writedata & be_bits;
  assign be_w    = be_bits[DATA_W-1:0];
  assign wd_w    = wd_be[DATA_W-1:0];
  assign div_wr  = wr_en && (reg_sel == REG_DIV) && (|byteenable);

  // Per-channel data and blink-mask updates; out-of-range channel indices match no channel
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      data_d[c] = data_q[c];
      mask_d[c] = mask_q[c];
      if (wr_en && (ch_idx == CH_AW'(c))) begin
        case (reg_sel)
          REG_DATA:   data_d[c] = (data_q[c] & ~be_w) | wd_w;
          REG_SET:    data_d[c] = data_q[c] | wd_w;
          REG_CLEAR:  data_d[c] = data_q[c] & ~wd_w;
          REG_TOGGLE: data_d[c] = data_q[c] ^ wd_w;
          REG_MASK:   mask_d[c] = (mask_q[c] & ~be_w) | wd_w;
          default:    ;
        endcase
      end
    end
  end

  // Shared blink prescaler; a divider write restarts the half-period and beats a coincident wrap
  always_comb begin
    blink_div_d = blink_div_q;
    counter_d   = counter_q;
    phase_d     = phase_q;
    if (blink_div_q == 32'd0) begin
      counter_d = 32'd0;
      phase_d   = 1'b0;
    end else if (counter_q == blink_div_q) begin
      counter_d = 32'd0;
      phase_d   = ~phase_q;
    end else begin
      counter_d = counter_q + 32'd1;
    end
    if (div_wr) begin
      blink_div_d = (blink_div_q & ~be_bits) | wd_be;
      counter_d   = 32'd0;
      phase_d     = 1'b0;
    end
  end

  // Read mux into the latency-1 read register; holds when no read is strobed
  always_comb begin
    logic [31:0] rd_word;
    rd_word = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == CH_AW'(c)) begin
        if (reg_sel == REG_DATA) rd_word[DATA_W-1:0] = data_q[c];
        if (reg_sel == REG_MASK) rd_word[DATA_W-1:0] = mask_q[c];
      end
    end
    if (reg_sel == REG_DIV)    rd_word = blink_div_q;
    if (reg_sel == REG_STATUS) rd_word = {31'd0, phase_q};
    readdata_d = rd_en ? rd_word : readdata_q;
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= '0;
        mask_q[c] <= '0;
      end
      blink_div_q <= 32'd0;
      counter_q   <= 32'd0;
      phase_q     <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= data_d[c];
        mask_q[c] <= mask_d[c];
      end
      blink_div_q <= blink_div_d;
      counter_q   <= counter_d;
      phase_q     <= phase_d;
      readdata_q  <= readdata_d;
    end
  end

  // Outputs are a pure function of the registers so reset zeroes them without waiting for a clock
  always_comb begin
    out_port = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_port[c*DATA_W +: DATA_W] = data_q[c] ^ (mask_q[c] & {DATA_W{phase_q}});
    end
  end

  assign readdata = readdata_q;

endmodule
